// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver; deserialises one frame into a one-entry
//                valid/ready buffer, flagging framing errors and overruns.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT_P = 221,
    parameter int DATA_BITS_P    = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   rx_serial_i,
    output logic [DATA_BITS_P-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT_P);
    localparam int c_idx_w = (DATA_BITS_P > 1) ? $clog2(DATA_BITS_P) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT_P / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT_P - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS_P - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_brk   = 3'd4;

    logic [1:0]             r_sync;
    logic [2:0]             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [DATA_BITS_P-1:0] r_shift;
    logic [DATA_BITS_P-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_rx_s;
    logic [2:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [c_idx_w-1:0]     w_idx_nxt;
    logic [DATA_BITS_P-1:0] w_shift_nxt;
    logic                   w_stop_ok;
    logic                   w_stop_bad;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], rx_serial_i};
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) w_state_nxt = c_st_start;
            end
            c_st_start: begin
                // Re-check the start bit at mid-bit; short glitches fall back to idle.
                if (r_cnt == c_cnt_half) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS_P-1:1]};
                    if (r_idx == c_idx_last) w_state_nxt = c_st_stop;
                    else                     w_idx_nxt   = r_idx + c_idx_one;
                end
            end
            c_st_stop: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = c_st_brk;
                    end
                end
            end
            c_st_brk: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = c_st_idle;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // One-entry output buffer; a slot freed by acceptance this cycle can take the new byte.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_stop_ok) begin
                if (!r_valid || ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx with a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int CPB_SLOW = 221;
    localparam int BIT_SLOW = 228;   // 221 * 1.03, rounded up

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx_slow;
    logic       ready, ready_s;
    logic [7:0] data, data_s;
    logic       valid, valid_s, ferr, ferr_s, ovr, ovr_s;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT_P(CPB), .DATA_BITS_P(8)) u_dut (
        .clk_i(clk), .reset_i(rst), .rx_serial_i(rx), .data_o(data),
        .valid_o(valid), .ready_i(ready), .frame_err_o(ferr), .overrun_o(ovr)
    );

    uart_rx #(.CLKS_PER_BIT_P(CPB_SLOW), .DATA_BITS_P(8)) u_dut_slow (
        .clk_i(clk), .reset_i(rst), .rx_serial_i(rx_slow), .data_o(data_s),
        .valid_o(valid_s), .ready_i(ready_s), .frame_err_o(ferr_s), .overrun_o(ovr_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: what the consumer must eventually see.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    bit         m_full   = 1'b0;
    logic [7:0] m_byte   = 8'h00;

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit rdy);
        if (!stop_ok)            exp_ferr++;
        else if (m_full && !rdy) exp_ovr++;
        else if (rdy)            exp_q.push_back(b);
        else begin
            m_full = 1'b1;
            m_byte = b;
        end
    endfunction

    function automatic void model_accept();
        if (m_full) begin
            exp_q.push_back(m_byte);
            m_full = 1'b0;
        end
    endfunction

    // Per-cycle observation of the fast DUT.
    logic [7:0] got_q[$];
    int         ferr_cnt = 0, ovr_cnt = 0, vhi_cnt = 0;
    logic       prev_valid = 1'b0, prev_acc = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
            prev_ovr   = 1'b0;
        end else begin
            if (prev_valid && !prev_acc) begin
                chk("hold_valid", 32'(valid), 32'd1);
                chk("hold_data", 32'(data), 32'(prev_data));
            end
            if (ferr || ovr) begin
                chk("pulse_excl", 32'(ferr & ovr), 32'd0);
                chk("pulse_len", 32'({prev_ferr, prev_ovr} & {ferr, ovr}), 32'd0);
            end
            if (ferr)  ferr_cnt++;
            if (ovr)   ovr_cnt++;
            if (valid) vhi_cnt++;
            if (valid && ready) got_q.push_back(data);
            prev_valid = valid;
            prev_acc   = valid && ready;
            prev_data  = data;
            prev_ferr  = ferr;
            prev_ovr   = ovr;
        end
    end

    logic [7:0] got_s[$];
    int         sferr = 0, sovr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_s && ready_s) got_s.push_back(data_s);
            if (ferr_s) sferr++;
            if (ovr_s)  sovr++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int bt, input bit slow);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (slow) rx_slow = f[i];
            else      rx      = f[i];
            cycles(bt);
        end
    endtask

    task automatic check_test(input string t);
        chk({t, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({t, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({t, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        chk({t, "_ovr"}, 32'(ovr_cnt), 32'(exp_ovr));
        chk({t, "_valid"}, 32'(valid), 32'(m_full));
        if (m_full) chk({t, "_data"}, 32'(data), 32'(m_byte));
        got_q.delete();
        exp_q.delete();
        ferr_cnt = 0; ovr_cnt = 0; vhi_cnt = 0;
        exp_ferr = 0; exp_ovr = 0;
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; rx = 1'b1; rx_slow = 1'b1; ready = 1'b0; ready_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        idle(2 * CPB);

        // 1: single frame, consumer always ready
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, CPB, 1'b0); model_frame(8'hA5, 1'b1, 1'b1);
        idle(2 * CPB);
        chk("t1_vhi_cycles", 32'(vhi_cnt), 32'd1);
        chk("t1_lit_byte", 32'(got_q.size() > 0 ? got_q[0] : 8'hxx), 32'h0A5);
        check_test("t1");

        // 2: overrun while buffer held
        ready = 1'b0;
        send_frame(8'h3C, 1'b1, CPB, 1'b0); model_frame(8'h3C, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("t2_held_valid", 32'(valid), 32'd1);
        chk("t2_held_data", 32'(data), 32'h3C);
        send_frame(8'h81, 1'b1, CPB, 1'b0); model_frame(8'h81, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("t2_lit_ovr", 32'(ovr_cnt), 32'd1);
        ready = 1'b1; cycles(1); ready = 1'b0; model_accept();
        cycles(2);
        chk("t2_lit_valid_off", 32'(valid), 32'd0);
        chk("t2_lit_data_kept", 32'(data), 32'h3C);
        check_test("t2");

        // 3: framing error then line held low
        ready = 1'b1;
        send_frame(8'h55, 1'b0, CPB, 1'b0); model_frame(8'h55, 1'b0, 1'b1);
        rx = 1'b0;
        cycles(20 * CPB);
        idle(2 * CPB);
        chk("t3_lit_ferr", 32'(ferr_cnt), 32'd1);
        chk("t3_lit_no_valid", 32'(vhi_cnt), 32'd0);
        send_frame(8'h12, 1'b1, CPB, 1'b0); model_frame(8'h12, 1'b1, 1'b1);
        idle(2 * CPB);
        chk("t3_lit_data", 32'(data), 32'h12);
        check_test("t3");

        // 4: short low glitch on idle line
        rx = 1'b0;
        cycles(5);
        idle(3 * CPB);
        chk("t4_glitch_valid", 32'(vhi_cnt), 32'd0);
        chk("t4_glitch_err", 32'(ferr_cnt + ovr_cnt), 32'd0);
        send_frame(8'h7E, 1'b1, CPB, 1'b0); model_frame(8'h7E, 1'b1, 1'b1);
        idle(2 * CPB);
        check_test("t4");

        // 5: asynchronous reset in the middle of data bit 4
        b = 8'hC3;
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = b[4];
        cycles(8);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_data", 32'(data), 32'd0);
        chk("t5_rst_valid", 32'(valid), 32'd0);
        chk("t5_rst_pulses", 32'({ferr, ovr}), 32'd0);
        m_full = 1'b0;
        rx = 1'b1;
        cycles(3);
        rst = 1'b0;
        idle(2 * CPB);
        got_q.delete(); ferr_cnt = 0; ovr_cnt = 0; vhi_cnt = 0;
        send_frame(8'hF0, 1'b1, CPB, 1'b0); model_frame(8'hF0, 1'b1, 1'b1);
        idle(2 * CPB);
        chk("t5_lit_data", 32'(data), 32'hF0);
        check_test("t5");

        // 6a: back-to-back frames, nominal rate
        send_frame(8'h00, 1'b1, CPB, 1'b0); model_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, CPB, 1'b0); model_frame(8'hFF, 1'b1, 1'b1);
        idle(2 * CPB);
        check_test("t6a");

        // 6b: back-to-back frames at default divider with a 3% slow transmitter
        send_frame(8'h00, 1'b1, BIT_SLOW, 1'b1);
        send_frame(8'hFF, 1'b1, BIT_SLOW, 1'b1);
        rx_slow = 1'b1;
        cycles(2 * BIT_SLOW);
        chk("t6b_nbytes", 32'(got_s.size()), 32'd2);
        chk("t6b_byte0", 32'(got_s.size() > 0 ? got_s[0] : 8'hxx), 32'h00);
        chk("t6b_byte1", 32'(got_s.size() > 1 ? got_s[1] : 8'hxx), 32'hFF);
        chk("t6b_errs", 32'(sferr + sovr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
